// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
//   Shared types and helpers for the time-multiplexed fixed-point neuron.
//   - act_mode_t : activation selector encoding (3 is reserved, behaves linear)
//   - state_t    : sequencer states of neuron_mac_seq
//   - sat_shift  : rescale an accumulator to the output Q format and clamp it
//                  to the signed output range, reporting whether it clamped
// -----------------------------------------------------------------------------
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_LIN  = 2'd0,
    ACT_RELU = 2'd1,
    ACT_STEP = 2'd2
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    HOLD
  } state_t;

  // Widest configuration the helper supports; callers sign-extend into it.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ACC_W  = 2 * MAX_DATA_W + 32;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] value;  // low data_w bits hold the clamped result
    logic                  sat;
  } sat_res_t;

  // Arithmetic right shift by frac_w (rounds toward -inf), then clamp to
  // [-2^(data_w-1), 2^(data_w-1)-1]. Called with constant widths, so the
  // shifts fold away in synthesis.
  function automatic sat_res_t sat_shift(input logic signed [MAX_ACC_W-1:0] acc,
                                         input int frac_w,
                                         input int data_w);
    logic signed [MAX_ACC_W-1:0] s;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    sat_res_t res;
    s  = acc >>> frac_w;
    hi = '1;
    hi = hi >> (MAX_ACC_W - data_w + 1);  // 2^(data_w-1) - 1
    lo = ~hi;                             // -2^(data_w-1)
    res.sat = 1'b1;
    if (s > hi) begin
      res.value = hi[MAX_DATA_W-1:0];
    end else if (s < lo) begin
      res.value = lo[MAX_DATA_W-1:0];
    end else begin
      res.value = s[MAX_DATA_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_act.sv
// -----------------------------------------------------------------------------
// neuron_act
//   Combinational output stage: rescale + saturate the accumulator, then apply
//   the selected activation to the clamped value.
//   Ports:
//     acc_i  in  ACC_W   signed accumulator, Q(.)(2*FRAC_W)
//     mode_i in  2       activation select (act_mode_t, 3 -> linear)
//     data_o out DATA_W  activated result, Q(DATA_W-FRAC_W).FRAC_W
//     sat_o  out 1       pre-activation value was clamped
// -----------------------------------------------------------------------------
module neuron_act
  import neuron_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 70
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [1:0]        mode_i,
  output logic        [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

  sat_res_t                 res;
  logic signed [DATA_W-1:0] clamped;
  logic                     unused_val;

  assign res        = sat_shift(MAX_ACC_W'(acc_i), FRAC_W, DATA_W);
  assign clamped    = res.value[DATA_W-1:0];
  assign sat_o      = res.sat;
  // Bits above DATA_W are only sign copies of the clamped value.
  assign unused_val = ^res.value;

  always_comb begin
    data_o = clamped;
    case (mode_i)
      ACT_RELU: if (clamped[DATA_W-1]) data_o = '0;
      ACT_STEP: data_o = (!clamped[DATA_W-1] && (|clamped)) ? ONE : '0;
      default:  ;  // linear and reserved pass the clamped value through
    endcase
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
//   Time-multiplexed fixed-point neuron: captures N_INPUTS samples, weights and
//   a bias, accumulates LANES products per cycle, then saturates, activates and
//   presents one result over a valid/ready handshake.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  input handshake (in_ready only in IDLE)
//     in_data              N_INPUTS packed signed samples
//     weight               N_INPUTS packed weights, bias in the top entry
//     act_mode             0 linear, 1 ReLU, 2 step, 3 linear
//     out_valid / out_ready output handshake; outputs held under backpressure
//     out_data, out_sat    activated result and clamp flag
// -----------------------------------------------------------------------------
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int LANES    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS*DATA_W-1:0]     in_data,
  input  logic [(N_INPUTS+1)*DATA_W-1:0] weight,
  input  logic [1:0]                     act_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_sat
);

  localparam int BEATS = (N_INPUTS + LANES - 1) / LANES;
  localparam int PAD_N = BEATS * LANES;
  localparam int VEC_W = PAD_N * DATA_W;
  localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS + 1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [VEC_W-1:0]           data_q, data_d;
  logic [VEC_W-1:0]           wgt_q, wgt_d;
  logic [1:0]                 mode_q, mode_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]    beat_sum;
  logic signed [2*DATA_W-1:0] prod [LANES];
  logic signed [DATA_W-1:0]   bias;
  logic [DATA_W-1:0]          act_data;
  logic                       act_sat;
  logic                       accept;
  logic                       last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));
  assign bias      = weight[N_INPUTS*DATA_W +: DATA_W];

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = FINISH;
      FINISH:                 state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

  // ---------------------------------------------------------------- MAC tree
  // The lowest LANES entries of the shifting capture registers feed the
  // multipliers; padding entries beyond N_INPUTS are zero, so the ragged last
  // beat adds nothing for them.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [2*DATA_W-1:0] a_ext, b_ext;
    assign a_ext   = {{DATA_W{data_q[(l+1)*DATA_W-1]}}, data_q[l*DATA_W +: DATA_W]};
    assign b_ext   = {{DATA_W{wgt_q[(l+1)*DATA_W-1]}},  wgt_q[l*DATA_W +: DATA_W]};
    assign prod[l] = a_ext * b_ext;
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) beat_sum = beat_sum + ACC_W'(prod[l]);
  end

  neuron_act #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_act (
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .data_o (act_data),
    .sat_o  (act_sat)
  );

  // ---------------------------------------------------------------- datapath
  always_comb begin
    data_d     = data_q;
    wgt_d      = wgt_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    beat_d     = beat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (accept) begin
      data_d = VEC_W'(in_data);
      wgt_d  = VEC_W'(weight[N_INPUTS*DATA_W-1:0]);
      mode_d = act_mode;
      acc_d  = ACC_W'(bias) <<< FRAC_W;  // bias aligned to the product Q format
      beat_d = '0;
    end else if (state_q == ACCUM) begin
      data_d = data_q >> (LANES * DATA_W);
      wgt_d  = wgt_q >> (LANES * DATA_W);
      acc_d  = acc_q + beat_sum;
      beat_d = beat_q + 1'b1;
    end else if (state_q == FINISH) begin
      out_data_d = act_data;
      out_sat_d  = act_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      beat_q     <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      beat_q     <= beat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // NOTE: capture registers carry no reset: they are always loaded on accept
  // before any beat reads them, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    wgt_q  <= wgt_d;
    mode_q <= mode_d;
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_seq
//   Directed bench for neuron_mac_seq at default parameters plus a second
//   instance with N_INPUTS=5, LANES=2 for the ragged last beat. Expected
//   results are queued when a transaction is sent and popped when out_valid
//   is observed.
// -----------------------------------------------------------------------------
module tb_neuron_mac_seq;

  typedef struct {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  act_mode;
  logic        sel;  // 0: default instance, 1: small ragged instance

  logic [31:0] xin [32];
  logic [31:0] w   [32];
  logic [31:0] bias;

  logic [32*32-1:0] in_data_l;
  logic [33*32-1:0] weight_l;
  logic [5*32-1:0]  in_data_s;
  logic [6*32-1:0]  weight_s;

  logic        in_ready_l, out_valid_l, out_sat_l;
  logic        in_ready_s, out_valid_s, out_sat_s;
  logic [31:0] out_data_l, out_data_s;

  logic        in_ready, out_valid, out_sat;
  logic [31:0] out_data;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data_l = '0;
    weight_l  = '0;
    in_data_s = '0;
    weight_s  = '0;
    for (int i = 0; i < 32; i++) begin
      in_data_l[i*32 +: 32] = xin[i];
      weight_l[i*32 +: 32]  = w[i];
    end
    weight_l[32*32 +: 32] = bias;
    for (int i = 0; i < 5; i++) begin
      in_data_s[i*32 +: 32] = xin[i];
      weight_s[i*32 +: 32]  = w[i];
    end
    weight_s[5*32 +: 32] = bias;
  end

  assign in_ready  = sel ? in_ready_s  : in_ready_l;
  assign out_valid = sel ? out_valid_s : out_valid_l;
  assign out_sat   = sel ? out_sat_s   : out_sat_l;
  assign out_data  = sel ? out_data_s  : out_data_l;

  neuron_mac_seq dut_l (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !sel),
    .in_ready  (in_ready_l),
    .in_data   (in_data_l),
    .weight    (weight_l),
    .act_mode  (act_mode),
    .out_valid (out_valid_l),
    .out_ready (out_ready && !sel),
    .out_data  (out_data_l),
    .out_sat   (out_sat_l)
  );

  neuron_mac_seq #(
    .N_INPUTS (5),
    .DATA_W   (32),
    .FRAC_W   (16),
    .LANES    (2)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel),
    .in_ready  (in_ready_s),
    .in_data   (in_data_s),
    .weight    (weight_s),
    .act_mode  (act_mode),
    .out_valid (out_valid_s),
    .out_ready (out_ready && sel),
    .out_data  (out_data_s),
    .out_sat   (out_sat_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact wide-integer dot product, Q16 rescale, clamp, activation.
  function automatic exp_t model(input int n, input logic [1:0] mode);
    logic signed [127:0] acc, s, a, b, hi, lo;
    exp_t e;
    hi  = 128'sh7fff_ffff;
    lo  = -hi - 128'sd1;
    acc = 128'($signed(bias)) * 128'sd65536;
    for (int i = 0; i < n; i++) begin
      a   = 128'($signed(xin[i]));
      b   = 128'($signed(w[i]));
      acc = acc + a * b;
    end
    s     = acc >>> 16;
    e.sat = 1'b1;
    if (s > hi)      e.data = 32'h7fff_ffff;
    else if (s < lo) e.data = 32'h8000_0000;
    else begin
      e.data = s[31:0];
      e.sat  = 1'b0;
    end
    case (mode)
      2'd1:    if (e.data[31]) e.data = 32'h0;
      2'd2:    e.data = ($signed(e.data) > 0) ? 32'h0001_0000 : 32'h0;
      default: ;
    endcase
    return e;
  endfunction

  task automatic fill(input logic [31:0] x, input logic [31:0] wv, input logic [31:0] b);
    for (int i = 0; i < 32; i++) begin
      xin[i] = x;
      w[i]   = wv;
    end
    bias = b;
  endtask

  // Drives one transaction at a falling edge; returns half a cycle after the
  // accept edge with in_valid low.
  task automatic send(input logic [1:0] mode, input logic [31:0] ed, input logic es,
                      input string tag);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    act_mode = mode;
    in_valid = 1'b1;
    sb.push_back('{ed, es});
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ":busy"}, 64'(in_ready), 64'd0);
  endtask

  // Waits for out_valid (latency counted in cycles after the accept edge),
  // checks the result, holds out_ready low for 'stall' cycles, then consumes.
  task automatic receive(input string tag, input int lat, input int stall);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(lat));
    e = (sb.size() != 0) ? sb.pop_front() : '{32'hxxxx_xxxx, 1'bx};
    check({tag, ":data"}, 64'(out_data), 64'(e.data));
    check({tag, ":sat"},  64'(out_sat),  64'(e.sat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ":hold"}, {29'd0, out_valid, in_ready, out_sat, out_data},
            {29'd0, 1'b1, 1'b0, e.sat, e.data});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":release"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [1:0] m;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    act_mode  = 2'd0;
    sel       = 1'b0;
    fill(32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset:out", 64'({out_valid, out_sat, out_data}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset:in_ready", 64'(in_ready), 64'd1);

    // Case 1: 32 * 1.0 * 0.5 + 1.0 = 17.0
    fill(32'h0001_0000, 32'h0000_8000, 32'h0001_0000);
    send(2'd0, 32'h0011_0000, 1'b0, "c1");
    receive("c1", 9, 0);

    // Case 2: 32 * -1.0 = -32.0, then ReLU
    fill(32'hFFFF_0000, 32'h0001_0000, 32'h0);
    send(2'd0, 32'hFFE0_0000, 1'b0, "c2_lin");
    receive("c2_lin", 9, 0);
    send(2'd1, 32'h0, 1'b0, "c2_relu");
    receive("c2_relu", 9, 0);

    // Case 3: saturation both ways
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    send(2'd0, 32'h7FFF_FFFF, 1'b1, "c3_pos");
    receive("c3_pos", 9, 0);
    fill(32'h7FFF_FFFF, 32'h8000_0001, 32'h8000_0001);
    send(2'd0, 32'h8000_0000, 1'b1, "c3_neg");
    receive("c3_neg", 9, 0);

    // Case 4: step activation around zero, reserved mode is linear
    fill(32'h0, 32'h0, 32'h0);
    xin[0] = 32'h0001_0000;
    w[0]   = 32'h0000_8000;
    send(2'd2, 32'h0001_0000, 1'b0, "c4_pos");
    receive("c4_pos", 9, 0);
    fill(32'h0, 32'h0, 32'h0);
    send(2'd2, 32'h0, 1'b0, "c4_zero");
    receive("c4_zero", 9, 0);
    fill(32'h0, 32'h0, 32'hFFFD_0000);
    send(2'd2, 32'h0, 1'b0, "c4_neg");
    receive("c4_neg", 9, 0);
    send(2'd3, 32'hFFFD_0000, 1'b0, "c4_mode3");
    receive("c4_mode3", 9, 0);

    // Shift truncates toward -inf: -2^-32 becomes -2^-16
    fill(32'h0, 32'h0, 32'h0);
    xin[0] = 32'h0000_0001;
    w[0]   = 32'hFFFF_FFFF;
    send(2'd0, 32'hFFFF_FFFF, 1'b0, "trunc");
    receive("trunc", 9, 0);

    // Case 5: inputs change and in_valid stays high while busy; backpressure
    fill(32'h0001_0000, 32'h0000_8000, 32'h0001_0000);
    send(2'd0, 32'h0011_0000, 1'b0, "c5");
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    act_mode = 2'd2;
    in_valid = 1'b1;
    receive("c5", 9, 6);

    // Case 6: reset during accumulation discards the transaction
    fill(32'h0001_0000, 32'h0000_8000, 32'h0001_0000);
    send(2'd0, 32'h0011_0000, 1'b0, "c6_abort");
    repeat (4) @(negedge clk);
    check("c6:mid_accum", 64'({out_valid, in_ready}), 64'd0);
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    check("c6:in_reset", 64'({out_valid, out_sat, out_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("c6:after", 64'({out_valid, in_ready}), 64'd1);
    send(2'd0, 32'h0011_0000, 1'b0, "c6_next");
    receive("c6_next", 9, 0);

    // Random vectors against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        xin[i] = (r == 2) ? $urandom() : ($urandom_range(0, 262143) - 32'd131072);
        w[i]   = (r == 2) ? $urandom() : ($urandom_range(0, 262143) - 32'd131072);
      end
      bias = $urandom_range(0, 1048575) - 32'd524288;
      m    = 2'($urandom_range(0, 3));
      e    = model(32, m);
      send(m, e.data, e.sat, $sformatf("rand%0d", r));
      receive($sformatf("rand%0d", r), 9, r);
    end

    // Ragged last beat: N_INPUTS=5, LANES=2 -> 5 * 0.5 + 1.0 = 3.5
    sel = 1'b1;
    @(negedge clk);
    fill(32'h0001_0000, 32'h0000_8000, 32'h0001_0000);
    send(2'd0, 32'h0003_8000, 1'b0, "ragged");
    receive("ragged", 4, 0);
    for (int i = 0; i < 32; i++) begin
      xin[i] = $urandom();
      w[i]   = $urandom_range(0, 262143) - 32'd131072;
    end
    bias = $urandom();
    e    = model(5, 2'd0);
    send(2'd0, e.data, e.sat, "ragged_rand");
    receive("ragged_rand", 4, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
